uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 102 ++++++++++
 tb/tb_uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and sequencer state encoding for the UART transmit FIFO.
package uart_pkg;

    localparam int DBITS_DEF  = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO: storage, pointers and an occupancy counter.
// full/empty/count come from registered state only. A read of an empty FIFO
// and a write to a full FIFO are both ignored.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DBITS  = DBITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBITS-1:0]  wr_data,
    input  logic              rd_en,
    output logic [DBITS-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DBITS-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // count never exceeds DEPTH, so its MSB alone marks the full condition
    assign full    = count[ADDR_W];
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at 2**ADDR_W; count tracks net occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side transmit FIFO feeding a UART transmitter.
// The sequencer pops one byte in IDLE, pulses tx_start from LOAD, then waits
// in WAIT for the transmitter's tx_done_tick before fetching the next byte.
// Optional feature macro: UART_TX_FIFO_OVF_EN adds a sticky overflow flag
// (set by any dropped write) with an ovf_clr input.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DBITS  = DBITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBITS-1:0]  wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [DBITS-1:0]  tx_din,
    input  logic              tx_done_tick,
    output logic              tx_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic              overflow,
    input  logic              ovf_clr
`endif
);

    tx_state_t        state;
    logic             pop;
    logic [DBITS-1:0] head;

    assign pop = (state == IDLE) && !empty;

    uart_fifo #(
        .DBITS  (DBITS),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Launch sequencer; tx_start is registered so it is high for the cycle
    // after LOAD, with tx_din already stable since the IDLE pop
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_din   <= '0;
            tx_start <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_din  <= head;
                        tx_busy <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    tx_start <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic drop;
    assign drop = wr_en && full;

    // Sticky overflow; a drop on the same edge as ovf_clr wins
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted writes push the expected byte,
// a negedge monitor pops and compares on every tx_start cycle.
module tb_uart_tx_fifo;

    localparam int DBITS  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [DBITS-1:0]  wr_data = '0;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              tx_start;
    logic [DBITS-1:0]  tx_din;
    logic              tx_done_tick = 1'b0;
    logic              tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic              overflow;
    logic              ovf_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int starts = 0;
    logic [DBITS-1:0] sb [$];
    logic [DBITS-1:0] mon_exp;

    uart_tx_fifo #(.DBITS(DBITS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .tx_busy      (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every tx_start cycle must match the oldest expected byte
    always @(negedge clk) begin
        if (!reset && tx_start === 1'b1) begin
            starts++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_start: tx_din %0h, no byte expected", tx_din);
            end else begin
                mon_exp = sb.pop_front();
                chk("tx_din_order", 32'(tx_din), 32'(mon_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DBITS-1:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) sb.push_back(d);
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
    endtask

    task automatic wait_start(output int w);
        w = 0;
        while (tx_start !== 1'b1 && w < 30) begin
            tick(1);
            w++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0;
        int w;

        // Reset state
        reset = 1'b1;
        tick(2);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_din", 32'(tx_din), 0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("rst_ovf", 32'(overflow), 0);
`endif
        reset = 1'b0;
        tick(1);

        // Single byte: tx_start in the third cycle after the write
        s0 = starts;
        wr(8'hA5, 1'b1);
        chk("one_count1", 32'(count), 1);
        chk("one_empty0", 32'(empty), 0);
        tick(1);
        chk("one_count0", 32'(count), 0);
        chk("one_load_nostart", 32'(tx_start), 0);
        chk("one_busy", 32'(tx_busy), 1);
        tx_done_tick = 1'b1;            // in LOAD, must be ignored
        tick(1);
        tx_done_tick = 1'b0;
        chk("one_start", 32'(tx_start), 1);
        chk("one_din", 32'(tx_din), 32'hA5);
        tick(1);
        chk("one_start_1cyc", 32'(tx_start), 0);
        chk("one_load_done_ignored", 32'(tx_busy), 1);
        chk("one_npulses", 32'(starts - s0), 1);
        pulse_done();
        chk("one_idle", 32'(tx_busy), 0);
        chk("one_empty", 32'(empty), 1);

        // Fill: 16 writes, one popped into flight
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b1);
        chk("fill_count15", 32'(count), 15);
        chk("fill_notfull", 32'(full), 0);
        wr(8'h10, 1'b1);
        chk("fill_count16", 32'(count), 16);
        chk("fill_full", 32'(full), 1);
`ifdef UART_TX_FIFO_OVF_EN
        chk("fill_ovf0", 32'(overflow), 0);
`endif
        wr(8'h11, 1'b0);
        chk("drop_count16", 32'(count), 16);
        chk("drop_full", 32'(full), 1);
`ifdef UART_TX_FIFO_OVF_EN
        chk("drop_ovf1", 32'(overflow), 1);
`endif

        // Full FIFO: write and IDLE pop on the same edge -> write rejected
        pulse_done();
        chk("pop_idle_full", 32'(full), 1);
        wr(8'h55, 1'b0);
        chk("pop_wr_count15", 32'(count), 15);
        chk("pop_wr_notfull", 32'(full), 0);
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
`endif
        wr(8'h12, 1'b1);
        chk("refill_full", 32'(full), 1);
        wr_en   = 1'b1;
        wr_data = 8'h13;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b1;
`endif
        tick(1);
        wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
        chk("ovf_clr_vs_drop", 32'(overflow), 1);
`endif
        chk("refill_count16", 32'(count), 16);
        tick(3);

        // Drain: done 10 cycles after each tx_start, 3-cycle relaunch
        s0 = starts;
        pulse_done();
        for (int k = 0; k < 16; k++) begin
            wait_start(w);
            chk("drain_latency", 32'(w), 2);
            tick(9);
            pulse_done();
        end
        chk("drain_npulses", 32'(starts - s0), 16);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_idle", 32'(tx_busy), 0);
        chk("drain_sb_empty", 32'(sb.size()), 0);

        // Reset during WAIT with 5 bytes queued
        for (int i = 0; i < 6; i++) wr(8'(8'h20 + i), 1'b1);
        chk("midrst_count5", 32'(count), 5);
        chk("midrst_busy", 32'(tx_busy), 1);
        reset = 1'b1;
        tick(1);
        sb.delete();
        chk("midrst_count0", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_idle", 32'(tx_busy), 0);
        chk("midrst_nostart", 32'(tx_start), 0);
        chk("midrst_din0", 32'(tx_din), 0);
        reset = 1'b0;
        s0 = starts;
        tick(10);
        chk("midrst_quiet", 32'(starts - s0), 0);
        wr(8'h77, 1'b1);
        tick(3);
        chk("midrst_relaunch", 32'(starts - s0), 1);
        pulse_done();
        tick(2);
        chk("end_sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
